data_memory_controller: RTL
===========================

DATA_MEMORY_CONTROLLER -- requirements
Module: data_memory_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of ACCESS-state cycles allowed before the access is aborted.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 MEM_READ  in  4  load control from the decode stage: [3] load enable; [2:0] funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-005 MEM_WRITE  in  3  store control from the decode stage: [2] store enable; [1:0] size (00 SB, 01 SH, 10 SW).
REQ-006 ADDRESS  in  32  byte address (ALU result).
REQ-007 WRITE_DATA  in  32  store data (rs2).
REQ-008 READ_DATA  out  32  aligned, extended load result.
REQ-009 BUSYWAIT  out  1  pipeline stall request.
REQ-010 MISALIGNED  out  1  one-cycle pulse: access rejected for misalignment.
REQ-011 TIMEOUT  out  1  one-cycle pulse: access aborted, no MEM_ACK received.
REQ-012 MEM_ADDR  out  30  word address to backing memory.
REQ-013 MEM_WDATA  out  32  lane-replicated store data.
REQ-014 MEM_BYTE_EN  out  4  byte-lane enables.
REQ-015 MEM_RD / MEM_WR  out  1 each  read / write strobes.
REQ-016 MEM_RDATA  in  32  word read data; MEM_ACK  in  1  completion strobe.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE.
REQ-018 IDLE behaviour:
- A request is MEM_READ[3] or MEM_WRITE[2].
- A request makes BUSYWAIT high combinationally in the same cycle.
- At the edge, ADDRESS, WRITE_DATA and the decoded type are latched and the FSM moves to ACCESS.
REQ-019 Store priority: if both enables are high, the access is a store and the load is ignored.
REQ-020 Undefined load funct3 values (011, 110, 111) are treated as LW.
REQ-021 Misalignment: LH/LHU/SH with ADDRESS[0]=1, or LW/SW with ADDRESS[1:0]!=00, is rejected:
- no strobe is issued and BUSYWAIT stays low;
- MISALIGNED pulses in the next cycle;
- READ_DATA = 0;
- the FSM stays in IDLE.
REQ-022 ACCESS outputs:
- MEM_RD or MEM_WR is held high for the whole state.
- MEM_ADDR = latched ADDRESS[31:2].
- MEM_ADDR, MEM_WDATA and MEM_BYTE_EN are driven from the latched registers and are stable throughout ACCESS.
- BUSYWAIT is high.
REQ-023 Byte enables and store data:
- SB: MEM_BYTE_EN = 0001 << ADDRESS[1:0]; MEM_WDATA = byte replicated 4x.
- SH: MEM_BYTE_EN = 0011 << (2*ADDRESS[1]); MEM_WDATA = halfword replicated 2x.
- SW: MEM_BYTE_EN = 1111; MEM_WDATA = WRITE_DATA.
REQ-024 MEM_ACK in ACCESS:
- The strobes drop at the next edge and the FSM moves to DONE.
- For a load, READ_DATA is registered from MEM_RDATA: lane selected by ADDRESS[1:0]; sign-extended for LB/LH; zero-extended for LBU/LHU/LW.
REQ-025 Timeout: an 8-bit-minimum cycle counter clears on entry to ACCESS and increments each ACCESS cycle. When it reaches TIMEOUT_CYCLES without MEM_ACK:
- the strobes drop and the FSM moves to DONE;
- READ_DATA = 0;
- TIMEOUT pulses during DONE.
REQ-026 MEM_ACK and ACK coincident with the timeout limit: ACK wins (normal completion).
REQ-027 DONE lasts exactly one cycle:
- BUSYWAIT is low and READ_DATA is held so the pipeline advances.
- The next state is IDLE unconditionally; a request present during DONE is not accepted until IDLE.
REQ-028 MEM_ACK is ignored in IDLE and DONE.
REQ-029 READ_DATA holds its last value until the next load completion, misalignment or timeout.
REQ-030 Latency: an aligned access with MEM_ACK arriving k cycles after the strobe rises gives BUSYWAIT high for k+1 cycles, then one low DONE cycle.

Reset
REQ-031 RESET low asynchronously sets: FSM to IDLE; READ_DATA, MEM_ADDR, MEM_WDATA, MEM_BYTE_EN to 0; MEM_RD, MEM_WR, MISALIGNED, TIMEOUT to 0; counter to 0.
REQ-032 Reset mid-ACCESS drops the strobes immediately, without waiting for a clock edge; the aborted access is not retried.

Structure
REQ-033 Shared package dmem_pkg holds:
- the state encoding;
- funct3 load codes and store size codes;
- the byte-enable constants.
REQ-034 The combinational lane select and sign/zero extension is sub-module dmem_load_align, shared with future cache logic.

Verification
REQ-035 LB at 0x0000_1003, MEM_RDATA = 0x80FF_1234, ACK after 2 cycles -> READ_DATA = 0xFFFF_FF80, BUSYWAIT high 3 cycles.
REQ-036 SH at 0x0000_2002, WRITE_DATA = 0x1234_ABCD -> MEM_BYTE_EN = 1100, MEM_WDATA = 0xABCD_ABCD, MEM_ADDR = 0x800.
REQ-037 LW at 0x0000_0006 -> MISALIGNED one pulse, no MEM_RD, BUSYWAIT never high.
REQ-038 SW with MEM_ACK never asserted, TIMEOUT_CYCLES = 4 -> MEM_WR high 4 cycles, then TIMEOUT pulse, BUSYWAIT low in DONE.
REQ-039 RESET asserted in the 2nd ACCESS cycle of an LHU -> MEM_RD drops immediately, FSM in IDLE, all outputs 0.
REQ-040 Back-to-back LBU 0x3 then SB 0x1 -> two DONE cycles; second access starts from IDLE; MEM_BYTE_EN = 0010.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and decode helpers for the data memory controller
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic       is_store;
    logic [1:0] size;
    logic       is_unsigned;
  } access_t;

  // Stores win over loads; unknown load codes and the spare store size fall back to a word.
  function automatic access_t decode_access(input logic [2:0] funct3, input logic [2:0] mem_write);
    access_t a;
    a.is_store    = mem_write[2];
    a.size        = SZ_W;
    a.is_unsigned = 1'b0;
    if (mem_write[2]) begin
      if (mem_write[1:0] == SZ_B)      a.size = SZ_B;
      else if (mem_write[1:0] == SZ_H) a.size = SZ_H;
      else                             a.size = SZ_W;
    end else begin
      case (funct3)
        F3_LB:   a.size = SZ_B;
        F3_LH:   a.size = SZ_H;
        F3_LBU:  begin a.size = SZ_B; a.is_unsigned = 1'b1; end
        F3_LHU:  begin a.size = SZ_H; a.is_unsigned = 1'b1; end
        default: a.size = SZ_W;
      endcase
    end
    return a;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_H:    return offset[0];
      SZ_W:    return |offset;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_B:    return BE_BYTE << offset;
      SZ_H:    return BE_HALF << {offset[1], 1'b0};
      default: return BE_WORD;
    endcase
  endfunction

  // Lane replication lets the memory pick whichever lane its byte enables select.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// rtl/data_memory_controller_if.sv - pipeline and backing-memory signals of the data memory controller
interface data_memory_controller_if;

  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;
  logic        TIMEOUT;
  logic [29:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  modport slave (
    input  MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA, MEM_RDATA, MEM_ACK,
    output READ_DATA, BUSYWAIT, MISALIGNED, TIMEOUT,
    output MEM_ADDR, MEM_WDATA, MEM_BYTE_EN, MEM_RD, MEM_WR
  );

  modport master (
    output MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA, MEM_RDATA, MEM_ACK,
    input  READ_DATA, BUSYWAIT, MISALIGNED, TIMEOUT,
    input  MEM_ADDR, MEM_WDATA, MEM_BYTE_EN, MEM_RD, MEM_WR
  );

endinterface

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - lane select and sign/zero extension of a loaded word
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane and extend it to 32 bits.
  always_comb begin
    w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_B:    o_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    o_data = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// rtl/data_memory_controller.sv - load/store controller between pipeline and word-wide backing memory
module data_memory_controller
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input logic                      CLK,
  input logic                      RESET,
  data_memory_controller_if.slave  bus
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // The counter holds the number of ACCESS cycles already completed, so the
  // last permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic        w_req;
  logic        w_misaligned;
  logic        w_busy;
  access_t     w_acc;
  logic [31:0] w_load_data;

  state_t           r_state;
  access_t          r_acc;
  logic [1:0]       r_offset;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_read_data;
  logic [29:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_be;
  logic             r_mem_rd;
  logic             r_mem_wr;
  logic             r_misaligned;
  logic             r_timeout;

  assign w_req        = bus.MEM_READ[3] | bus.MEM_WRITE[2];
  assign w_acc        = decode_access(bus.MEM_READ[2:0], bus.MEM_WRITE);
  assign w_misaligned = w_req & is_misaligned(w_acc.size, bus.ADDRESS[1:0]);
  // Stall starts in the request cycle itself so the pipeline never advances past an accepted access.
  assign w_busy       = (r_state == ST_ACCESS) |
                        ((r_state == ST_IDLE) & w_req & ~w_misaligned);

  dmem_load_align u_load_align (
    .i_rdata    (bus.MEM_RDATA),
    .i_offset   (r_offset),
    .i_size     (r_acc.size),
    .i_unsigned (r_acc.is_unsigned),
    .o_data     (w_load_data)
  );

  // Access FSM with registered strobes, memory-side address/data and status pulses.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_offset     <= 2'b00;
      r_cnt        <= '0;
      r_read_data  <= 32'h0;
      r_mem_addr   <= 30'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_be     <= 4'h0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_misaligned) begin
              r_misaligned <= 1'b1;
              r_read_data  <= 32'h0;
            end else begin
              r_acc       <= w_acc;
              r_offset    <= bus.ADDRESS[1:0];
              r_mem_addr  <= bus.ADDRESS[31:2];
              r_mem_be    <= byte_enable(w_acc.size, bus.ADDRESS[1:0]);
              r_mem_wdata <= store_data(w_acc.size, bus.WRITE_DATA);
              r_mem_rd    <= ~w_acc.is_store;
              r_mem_wr    <= w_acc.is_store;
              r_cnt       <= '0;
              r_state     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // An acknowledge in the final permitted cycle still completes normally.
          if (bus.MEM_ACK) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (!r_acc.is_store) r_read_data <= w_load_data;
            r_state  <= ST_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_read_data <= 32'h0;
            r_timeout   <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.READ_DATA   = r_read_data;
  assign bus.BUSYWAIT    = w_busy;
  assign bus.MISALIGNED  = r_misaligned;
  assign bus.TIMEOUT     = r_timeout;
  assign bus.MEM_ADDR    = r_mem_addr;
  assign bus.MEM_WDATA   = r_mem_wdata;
  assign bus.MEM_BYTE_EN = r_mem_be;
  assign bus.MEM_RD      = r_mem_rd;
  assign bus.MEM_WR      = r_mem_wr;

endmodule
